// File: rtl/oam_dma_ctrl_pkg.sv
// Shared NES CPU-bus definitions for the sprite OAM DMA sequencer.
// Contents:
//   OAMDMA_REG_ADDR - CPU register whose write starts a DMA ($4014)
//   OAMDATA_ADDR    - PPU OAM data port that every DMA write targets ($2004)
//   dma_state_t     - sequencer states
//   bus_t           - one CPU-side bus cycle (cs active low, rd, wr, addr, wdata)
//   BUS_IDLE        - a bus cycle with no access
package oam_dma_ctrl_pkg;

  localparam logic [15:0] OAMDMA_REG_ADDR = 16'h4014;
  localparam logic [15:0] OAMDATA_ADDR    = 16'h2004;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } dma_state_t;

  typedef struct packed {
    logic        cs;
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } bus_t;

  localparam bus_t BUS_IDLE = '{cs: 1'b1, rd: 1'b0, wr: 1'b0, addr: 16'h0000, wdata: 8'h00};

endpackage

// File: rtl/oam_dma_ctrl.sv
// Sprite OAM DMA sequencer and CPU-bus owner.
// A CPU write to $4014 halts the CPU (cpu_rdy=0), then the block copies the
// 256 bytes of page {page,00..FF} into OAMDATA ($2004) as read/write pairs and
// returns the bus to the CPU.
//
// Parameters:
//   RD_LAT  - cycles a read address is held before its write cycle (1..3)
//   PAGE_W  - width of the page register (source address high byte, <= 8)
//
// Ports:
//   clk, rst_n        - CPU-cycle clock, asynchronous active-low reset
//   cpu_cs/rd/wr/addr/wdata - bus request from the 6502 core (cs active low)
//   cpu_rdy           - 0 while the CPU is halted
//   mem_cs/rd/wr/addr/wdata - muxed bus towards memory/IO (cs active low)
//   mem_rdata         - read data, valid RD_LAT cycles after the address
//   dma_active        - 1 while the DMA owns the bus
//   dbg_state         - current sequencer state, for observation
//
// Optional build macro OAM_DMA_TRACE_EN adds:
//   dma_xfer_cnt[15:0] - completed DMAs, saturating at 16'hFFFF
//   dma_last_byte[7:0] - last byte written to OAMDATA
module oam_dma_ctrl
  import oam_dma_ctrl_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int PAGE_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_cs,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [15:0]       cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic              cpu_rdy,
  output logic              mem_cs,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [15:0]       mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              dma_active,
  output dma_state_t        dbg_state
`ifdef OAM_DMA_TRACE_EN
  ,
  output logic [15:0]       dma_xfer_cnt,
  output logic [7:0]        dma_last_byte
`endif
);

  localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

  dma_state_t        state;
  logic [PAGE_W-1:0] page;
  logic [7:0]        idx;
  logic [1:0]        lat_cnt;
  logic              parity;   // 1 = odd CPU cycle
  logic              trigger;
  logic [15:0]       src_addr;
  bus_t              cpu_bus;
  bus_t              dma_bus;
  bus_t              out_bus;

`ifdef OAM_DMA_TRACE_EN
  logic [7:0]        last_byte;
  logic [15:0]       xfer_cnt;
  assign dma_xfer_cnt  = xfer_cnt;
  assign dma_last_byte = last_byte;
`endif

  assign trigger   = (cpu_cs == 1'b0) && cpu_wr && (cpu_addr == OAMDMA_REG_ADDR);
  // idx wraps within 8 bits, so the source never leaves the page.
  assign src_addr  = 16'({page, idx});
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      page       <= '0;
      idx        <= 8'h00;
      lat_cnt    <= 2'd0;
      parity     <= 1'b0;
      cpu_rdy    <= 1'b1;
      dma_active <= 1'b0;
`ifdef OAM_DMA_TRACE_EN
      last_byte  <= 8'h00;
      xfer_cnt   <= 16'h0000;
`endif
    end else begin
      parity <= ~parity;
      case (state)
        IDLE: begin
          if (trigger) begin
            page       <= PAGE_W'(cpu_wdata);
            state      <= HALT;
            cpu_rdy    <= 1'b0;
            dma_active <= 1'b1;
          end
        end
        HALT: begin
          // An odd halt cycle costs one extra ALIGN cycle before the first read.
          lat_cnt <= 2'd0;
          state   <= parity ? ALIGN : READ;
        end
        ALIGN: state <= READ;
        READ: begin
          if (lat_cnt == LAT_LAST) begin
            lat_cnt <= 2'd0;
            state   <= WRITE;
          end else begin
            lat_cnt <= lat_cnt + 2'd1;
          end
        end
        WRITE: begin
`ifdef OAM_DMA_TRACE_EN
          last_byte <= mem_rdata;
`endif
          idx <= idx + 8'd1;
          if (idx == 8'hFF) begin
            state      <= DONE;
            cpu_rdy    <= 1'b1;
            dma_active <= 1'b0;
          end else begin
            state <= READ;
          end
        end
        DONE: begin
          idx   <= 8'h00;
          state <= IDLE;
`ifdef OAM_DMA_TRACE_EN
          if (xfer_cnt != 16'hFFFF) xfer_cnt <= xfer_cnt + 16'd1;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Bus mux: while dma_active the CPU strobes are dropped entirely.
  always_comb begin
    cpu_bus = '{cs: cpu_cs, rd: cpu_rd, wr: cpu_wr, addr: cpu_addr, wdata: cpu_wdata};
    dma_bus = BUS_IDLE;
    case (state)
      READ: begin
        dma_bus.cs   = 1'b0;
        dma_bus.rd   = 1'b1;
        dma_bus.addr = src_addr;
      end
      WRITE: begin
        // Source memory holds its data until the edge that ends WRITE.
        dma_bus.cs    = 1'b0;
        dma_bus.wr    = 1'b1;
        dma_bus.addr  = OAMDATA_ADDR;
        dma_bus.wdata = mem_rdata;
      end
      default: dma_bus = BUS_IDLE;
    endcase
    out_bus   = dma_active ? dma_bus : cpu_bus;
    mem_cs    = out_bus.cs;
    mem_rd    = out_bus.rd;
    mem_wr    = out_bus.wr;
    mem_addr  = out_bus.addr;
    mem_wdata = out_bus.wdata;
  end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Directed bench for oam_dma_ctrl (RD_LAT=1, PAGE_W=8).
// Builds with or without OAM_DMA_TRACE_EN; trace outputs are checked when defined.
module tb_oam_dma_ctrl;
  import oam_dma_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_cs, cpu_rd, cpu_wr;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_rdy;
  logic        mem_cs, mem_rd, mem_wr;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;
  logic        dma_active;
  dma_state_t  dbg_state;
`ifdef OAM_DMA_TRACE_EN
  logic [15:0] dma_xfer_cnt;
  logic [7:0]  dma_last_byte;
`endif

  int checks = 0;
  int failures = 0;
  int n_done = 0;
  logic exp_align = 1'b0;
  logic tb_par;

  logic [7:0]  mem [0:65535];
  logic [7:0]  wr_q[$];
  logic [15:0] rd_q[$];
  logic [7:0]  exp_q[$];
  logic [15:0] exp_addr_q[$];

  oam_dma_ctrl #(.RD_LAT(1), .PAGE_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_cs(cpu_cs), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdy(cpu_rdy),
    .mem_cs(mem_cs), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .dma_active(dma_active), .dbg_state(dbg_state)
`ifdef OAM_DMA_TRACE_EN
    , .dma_xfer_cnt(dma_xfer_cnt), .dma_last_byte(dma_last_byte)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // Reference parity: 0 out of reset, toggles each cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_par <= 1'b0;
    else        tb_par <= ~tb_par;
  end

  // Synchronous memory, one-cycle read latency; holds data between reads.
  always @(posedge clk) begin
    if (!mem_cs && mem_rd) mem_rdata <= mem[mem_addr];
  end

  // Bus monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!mem_cs && mem_wr && mem_addr == 16'h2004) wr_q.push_back(mem_wdata);
    if (dma_active && !mem_cs && mem_rd) rd_q.push_back(mem_addr);
  end

  // ---------------- driver / check tasks ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle();
    cpu_cs = 1'b1; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
  endtask

  task automatic cycle();
    @(posedge clk); #1;
  endtask

  // Wait until the next trigger lands so that the HALT cycle has parity p.
  task automatic align_halt_parity(input logic p);
    for (int k = 0; k < 4; k++) begin
      if (tb_par == !p) break;
      cycle();
    end
  endtask

  // Called at posedge+1; issues one $4014 write and returns at the HALT cycle.
  task automatic trigger(input logic [7:0] pg);
    exp_align = ~tb_par;
    cpu_cs = 1'b0; cpu_wr = 1'b1; cpu_addr = 16'h4014; cpu_wdata = pg;
    @(negedge clk);
    check("trig_passthru_wr", 32'(mem_wr), 32'd1);
    check("trig_passthru_addr", 32'(mem_addr), 32'h4014);
    check("trig_rdy", 32'(cpu_rdy), 32'd1);
    cycle();
    bus_idle();
  endtask

  // Follows one DMA from HALT to IDLE; inj_c >= 0 forces a CPU $4014 write
  // in that cycle index (0 = HALT).
  task automatic measure(input logic [7:0] pg, input int inj_c, input string tag);
    int len;
    int mism;
    logic done;
    logic [7:0] e;
    logic [15:0] ea;
    len = 0; done = 1'b0; mism = 0;
    wr_q.delete(); rd_q.delete();
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (c == 0) begin
        check({tag, "_halt_state"}, 32'(dbg_state), 32'(HALT));
        check({tag, "_halt_bus_idle"}, 32'({mem_cs, mem_rd, mem_wr}), 32'b100);
        check({tag, "_halt_active"}, 32'(dma_active), 32'd1);
      end
      if (c == 1) check({tag, "_second_state"}, 32'(dbg_state), exp_align ? 32'(ALIGN) : 32'(READ));
      if (c == inj_c) begin
        check({tag, "_inj_addr_blocked"}, 32'(mem_addr == 16'h4014), 32'd0);
        check({tag, "_inj_active"}, 32'(dma_active), 32'd1);
      end
      if (cpu_rdy) begin done = 1'b1; break; end
      len++;
      if (c == inj_c - 1) begin
        cycle();
        cpu_cs = 1'b0; cpu_wr = 1'b1; cpu_addr = 16'h4014; cpu_wdata = 8'h77;
      end else if (c == inj_c) begin
        cycle();
        bus_idle();
      end
    end
    check({tag, "_finished"}, 32'(done), 32'd1);
    check({tag, "_halt_len"}, 32'(len), 32'd513 + 32'(exp_align));
    check({tag, "_done_state"}, 32'(dbg_state), 32'(DONE));
    check({tag, "_done_inactive"}, 32'(dma_active), 32'd0);
    check({tag, "_wr_count"}, 32'(wr_q.size()), 32'd256);
    check({tag, "_rd_count"}, 32'(rd_q.size()), 32'd256);
    for (int i = 0; i < 256; i++) begin
      exp_q.push_back(mem[{pg, 8'(i)}]);
      exp_addr_q.push_back({pg, 8'(i)});
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (wr_q.size() == 0) mism++;
      else if (wr_q.pop_front() !== e) mism++;
    end
    check({tag, "_wr_data_mism"}, 32'(mism), 32'd0);
    mism = 0;
    while (exp_addr_q.size() > 0) begin
      ea = exp_addr_q.pop_front();
      if (rd_q.size() == 0) mism++;
      else if (rd_q.pop_front() !== ea) mism++;
    end
    check({tag, "_rd_addr_mism"}, 32'(mism), 32'd0);
    cycle();
    check({tag, "_back_idle"}, 32'(dbg_state), 32'(IDLE));
    check({tag, "_rdy_after"}, 32'(cpu_rdy), 32'd1);
    n_done++;
`ifdef OAM_DMA_TRACE_EN
    check({tag, "_xfer_cnt"}, 32'(dma_xfer_cnt), 32'(n_done));
    check({tag, "_last_byte"}, 32'(dma_last_byte), 32'(mem[{pg, 8'hFF}]));
`endif
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bool_init: begin end
    for (int a = 0; a < 65536; a++) mem[a] = 8'(a * 7) ^ 8'h33;
    for (int i = 0; i < 256; i++) begin
      mem[16'h0200 + i] = 8'(i) ^ 8'h5A;
      mem[16'h0300 + i] = 8'(i) + 8'h80;
      mem[16'hFF00 + i] = ~8'(i);
    end
    bus_idle();

    // Reset state and passthrough while in reset.
    rst_n = 1'b0;
    #12;
    check("rst_cpu_rdy", 32'(cpu_rdy), 32'd1);
    check("rst_dma_active", 32'(dma_active), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    check("rst_mem_cs_passthru", 32'(mem_cs), 32'd1);
`ifdef OAM_DMA_TRACE_EN
    check("rst_xfer_cnt", 32'(dma_xfer_cnt), 32'd0);
    check("rst_last_byte", 32'(dma_last_byte), 32'd0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycle();

    // CPU read passes straight through while idle.
    cpu_cs = 1'b0; cpu_rd = 1'b1; cpu_addr = 16'h1234; cpu_wdata = 8'hAB;
    @(negedge clk);
    check("idle_mux", 32'({mem_cs, mem_rd, mem_wr, mem_addr, mem_wdata}), {7'd0, 1'b0, 1'b1, 1'b0, 16'h1234, 8'hAB});
    cycle();
    bus_idle();
    cycle();

    // Even HALT: 513 cycles, data $5A,$5B,$58...
    align_halt_parity(1'b0);
    trigger(8'h02);
    measure(8'h02, -1, "even");
    check("even_first_byte_model", 32'(mem[16'h0200]), 32'h5A);

    // Odd HALT: one ALIGN cycle, 514 cycles.
    align_halt_parity(1'b1);
    trigger(8'h02);
    measure(8'h02, -1, "odd");

    // Page $FF stays inside $FF00..$FFFF.
    align_halt_parity(1'b0);
    trigger(8'hFF);
    measure(8'hFF, -1, "page_ff");

    // Forced second $4014 write three cycles after the first is ignored.
    align_halt_parity(1'b0);
    trigger(8'h02);
    measure(8'h02, 2, "forced");

    // Reset at byte 100: asynchronous abort, no further writes.
    cycle();
    trigger(8'h02);
    wr_q.delete();
    for (int c = 0; c < 1000; c++) begin
      @(posedge clk);
      if (wr_q.size() >= 100) break;
    end
    check("abort_reached_100", 32'(wr_q.size() >= 100), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_rdy_async", 32'(cpu_rdy), 32'd1);
    check("abort_active_async", 32'(dma_active), 32'd0);
    check("abort_state_async", 32'(dbg_state), 32'(IDLE));
    wr_q.delete();
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_done = 0;
    repeat (5) cycle();
    check("abort_no_more_writes", 32'(wr_q.size()), 32'd0);
    trigger(8'h02);
    measure(8'h02, -1, "restart");

    // Two back-to-back DMAs.
    trigger(8'h02);
    measure(8'h02, -1, "b2b_a");
    trigger(8'h03);
    measure(8'h03, -1, "b2b_b");
`ifdef OAM_DMA_TRACE_EN
    check("b2b_last_is_03ff", 32'(dma_last_byte), 32'h7F);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
